// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle RV32I instruction sequencer with PC and control-flow resolution
//
// Owns the program counter and steps each instruction through
// FETCH -> DECODE -> EXECUTE -> WRITE_BACK, resolving branches, jal and jalr.
// A control-flow target that is not word aligned parks the sequencer in TRAP
// (when ALIGN_CHECK=1) until reset.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   run                   permission to start a new fetch
//   imem_req/imem_addr    fetch request and address (= pc)
//   imem_valid/imem_rdata fetched instruction handshake
//   instr                 latched current instruction
//   rs1_addr/rs2_addr     register-file read addresses
//   rs1_value/rs2_value   register-file read data, captured in DECODE
//   dmem_busy             holds EXECUTE while data memory is busy
//   rd_we/rd_addr/rd_wdata link write-back for jal/jalr
//   pc, state             current PC and FSM state
//   retire/retire_count   completion pulse and wrapping count
//   trap/trap_pc          sticky misaligned-target flag and offending target
module pc_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h1000),
  parameter int              EXEC_CYCLES = 2,
  parameter bit              ALIGN_CHECK = 1'b1,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_value,
  input  logic [XLEN-1:0]  rs2_value,
  input  logic             dmem_busy,
  output logic             rd_we,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  rd_wdata,
  output logic [XLEN-1:0]  pc,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             trap,
  output logic [XLEN-1:0]  trap_pc
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_WRITE_BACK = 3'd3, S_TRAP = 3'd4
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // The EXECUTE counter only needs to reach EXEC_CYCLES-1, where it saturates.
  localparam int            CW       = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm_i, imm_b, imm_j, jalr_sum, next_pc;
  logic              taken, is_link, misaligned, exec_done;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign imm_i  = XLEN'($signed(instr_q[31:20]));
  assign imm_b  = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));

  // Operands are frozen from DECODE, so next_pc stays stable through WRITE_BACK.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (op1_q == op2_q);
      3'b001:  taken = (op1_q != op2_q);
      3'b100:  taken = ($signed(op1_q) < $signed(op2_q));
      3'b101:  taken = !($signed(op1_q) < $signed(op2_q));
      3'b110:  taken = (op1_q < op2_q);
      3'b111:  taken = !(op1_q < op2_q);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = op1_q + imm_i;

  always_comb begin
    next_pc = pc_q + XLEN'(4);
    case (opcode)
      OP_BRANCH: if (taken) next_pc = pc_q + imm_b;
      OP_JAL:    next_pc = pc_q + imm_j;
      OP_JALR:   next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      default:   next_pc = pc_q + XLEN'(4);
    endcase
  end

  assign is_link    = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign misaligned = ALIGN_CHECK && (next_pc[1:0] != 2'b00);
  assign exec_done  = (cnt_q >= CNT_LAST) && !dmem_busy;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:      if (run && imem_valid) state_d = S_DECODE;
      S_DECODE:     state_d = S_EXECUTE;
      S_EXECUTE:    if (exec_done) state_d = S_WRITE_BACK;
      S_WRITE_BACK: state_d = misaligned ? S_TRAP : S_FETCH;
      S_TRAP:       state_d = S_TRAP;
      default:      state_d = S_FETCH;
    endcase
  end

  // Output logic; imem_req is gated by reset so it is low throughout reset.
  always_comb begin
    imem_req = reset && run && (state_q == S_FETCH);
    retire   = (state_q == S_WRITE_BACK) && !misaligned;
    rd_we    = retire && is_link && (instr_q[11:7] != 5'd0);
  end

  // Datapath registers
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      S_FETCH:  if (run && imem_valid) instr_d = imem_rdata;
      S_DECODE: begin
        op1_d = rs1_value;
        op2_d = rs2_value;
        cnt_d = '0;
      end
      S_EXECUTE: if (cnt_q < CNT_LAST) cnt_d = cnt_q + CW'(1);
      S_WRITE_BACK: begin
        if (misaligned) begin
          trap_d    = 1'b1;
          trap_pc_d = next_pc;
        end else begin
          pc_d   = next_pc;
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign rs1_addr     = instr_q[19:15];
  assign rs2_addr     = instr_q[24:20];
  assign rd_addr      = instr_q[11:7];
  assign rd_wdata     = pc_q + XLEN'(4);
  assign pc           = pc_q;
  assign state        = state_q;
  assign retire_count = rcnt_q;
  assign trap         = trap_q;
  assign trap_pc      = trap_pc_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised multi-cycle instruction sequencer for the RV32I core: owns the program counter, runs the FETCH/DECODE/EXECUTE/WRITE_BACK state machine, and resolves all control-flow (branches, jal, jalr). Sits between instruction memory, the register file and the execute/data-memory path. Extends the previous sequencer with:

- a memory-ready handshake;
- a data-memory stall input;
- signed/unsigned branch compare;
- jal/jalr link write-back;
- a misaligned-target trap;
- a retired-instruction counter.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h1000, PC value after reset
- EXEC_CYCLES, 2, minimum cycles spent in EXECUTE (≥1)
- ALIGN_CHECK, 1, 1 = trap on target with bits[1:0]≠0; 0 = no check
- CNT_W, 32, width of retire counter
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = allowed to start a new fetch
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_valid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched current instruction
- rs1_addr, rs2_addr  out  5 each  instr[19:15], instr[24:20]
- rs1_value, rs2_value  in  XLEN each  register-file read data
- dmem_busy  in  1  data memory not finished; holds EXECUTE
- rd_we  out  1  link write strobe
- rd_addr  out  5  instr[11:7]
- rd_wdata  out  XLEN  link value pc+4
- pc  out  XLEN  current PC
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, WRITE_BACK=3, TRAP=4
- retire  out  1  one-cycle pulse per completed instruction
- retire_count  out  CNT_W  retired instructions, wraps
- trap  out  1  sticky misaligned-target flag
- trap_pc  out  XLEN  offending target address

## Operation
- **FETCH:** imem_req = run, imem_addr = pc. On imem_valid && run: instr ← imem_rdata, go to DECODE. Otherwise hold with no timeout. imem_valid while run=0 is ignored.
- **DECODE:** exactly 1 cycle. Latches rs1_value/rs2_value into internal operands. Builds the imm_i/imm_b/imm_j sign-extended immediates from instr. Goes to EXECUTE with counter = 0.
- **EXECUTE:**
  - Counter increments each cycle.
  - Leaves when counter ≥ EXEC_CYCLES-1 and dmem_busy = 0.
  - Computes next_pc.
- **next_pc by opcode:**
  - 1100011 branch:
    - beq/bne use equality.
    - blt/bge use signed compare; bltu/bgeu use unsigned compare.
    - Taken: pc+imm_b. Not taken: pc+4.
    - funct3 010/011: pc+4.
  - 1101111 jal: pc+imm_j.
  - 1100111 jalr: (rs1+imm_i) with bit 0 cleared.
  - All other opcodes: pc+4.
  - All adds are modulo 2^XLEN.
- **WRITE_BACK, target aligned (or ALIGN_CHECK=0):**
  - pc ← next_pc.
  - retire = 1; retire_count += 1 (wraps to 0).
  - For jal/jalr with rd≠0: rd_we = 1, rd_wdata = old pc+4.
  - Go to FETCH.
- **WRITE_BACK, misaligned target with ALIGN_CHECK=1:**
  - Go to TRAP: trap ← 1, trap_pc ← next_pc.
  - pc unchanged; no retire; no rd_we.
- **TRAP:** absorbing. imem_req = 0. Exited only by reset.
- rd_we is never asserted for rd = x0.

## Timing
- **Reset (async assert, sync release):**
  - state = FETCH, pc = RESET_PC, instr = 0.
  - imem_req = 0 while reset is low.
  - rd_we = 0, retire = 0, retire_count = 0, trap = 0, trap_pc = 0.
- **Reset mid-instruction:** all of the above takes effect immediately. No partial pc update and no retire occur.
- **Minimum latency:** 1 (FETCH, imem_valid same cycle) + 1 + EXEC_CYCLES + 1 cycles per instruction. This is 5 cycles with defaults.
- **Pulse widths:** retire and rd_we are high for exactly the WRITE_BACK cycle. pc shows the new value the cycle after.
- **Operand capture:** rs1_value/rs2_value are sampled only at the DECODE edge. Later changes have no effect.
- **Simultaneous events:** dmem_busy = 1 on the final EXECUTE cycle extends EXECUTE one cycle per busy cycle. The counter saturates.

## Test plan
- **Reset + fetch handshake:** release reset, run = 1, imem_valid delayed 3 cycles, instr = 0x00000013 → pc goes 0x1000 → 0x1004. retire pulses once; retire_count = 1.
- **Signed vs unsigned branch:**
  - rs1 = 0xFFFFFFFF, rs2 = 1, blt imm_b = +16 at pc 0x1000 → pc = 0x1010.
  - Same operands with bltu → pc = 0x1004.
- **jal and jalr:**
  - jal rd = x1, imm_j = -8 at 0x1010 → pc = 0x1008, rd_we = 1, rd_addr = 1, rd_wdata = 0x1014.
  - jalr rs1 = 0x2001, imm_i = 0 → pc = 0x2000.
  - jal with rd = x0 → rd_we stays 0.
- **Misaligned trap:** beq taken with imm_b = 6 from 0x1000 → state = TRAP, trap = 1, trap_pc = 0x1006, pc stays 0x1000, imem_req = 0. Repeat with ALIGN_CHECK = 0 → pc = 0x1006, no trap.
- **Stall:** dmem_busy high for 4 cycles during EXECUTE → total instruction time = 5 + 4 cycles. Exactly one retire.
- **Reset mid-operation:** assert reset in EXECUTE of a taken branch → immediately pc = RESET_PC and state = FETCH, with no retire pulse.
